hyperbus_trans_arbiter: RTL
===========================

// Module: hyperbus_trans_arbiter
// PURPOSE
// Round-robin arbiter sharing one HyperBus PHY transaction port among NumReq requesters
// (e.g. AXI front-end, register/config sequencer, debug master). Grants a whole transfer
// and holds it until its response completes: B handshake for writes, last R beat for reads.
// Routes the TX, RX and B channels to the current owner. Sits between requesters and hyperbus_phy.
// PARAMETERS
// NumReq    2   number of requesters, >=2; index 0 has priority after reset
// NumChips  2   chip-select width, passed through with each transfer
// PORTS
// clk_i            in   1               PHY clock
// rst_ni           in   1               async active-low reset
// req_trans_valid_i in  NumReq          per-requester transfer valid
// req_trans_ready_o out NumReq          per-requester transfer ready
// req_trans_i      in   NumReq x hyper_tf_t  per-requester transfer descriptor
// req_trans_cs_i   in   NumReq x NumChips    per-requester one-hot chip select
// req_tx_valid_i / req_tx_ready_o  in/out NumReq; req_tx_data_i in NumReq x 16; req_tx_strb_i in NumReq x 2; req_tx_last_i in NumReq
// req_rx_valid_o / req_rx_ready_i  out/in NumReq; req_rx_data_o out 16 (shared); req_rx_error_o, req_rx_last_o out 1 (shared)
// req_b_valid_o / req_b_ready_i    out/in NumReq; req_b_error_o out 1 (shared)
// phy_trans_valid_o/ready_i, phy_trans_o, phy_trans_cs_o     PHY transfer channel
// phy_tx_valid_o/ready_i, phy_tx_data_o[16], phy_tx_strb_o[2], phy_tx_last_o  PHY TX channel
// phy_rx_valid_i/ready_o, phy_rx_data_i[16], phy_rx_error_i, phy_rx_last_i    PHY RX channel
// phy_b_valid_i/ready_o, phy_b_error_i                       PHY B channel
// gnt_o            out  NumReq          one-hot current owner, 0 when Idle
// busy_o           out  1               high in any state other than Idle
// BEHAVIOUR
// - Reset: state Idle, rr pointer 0, gnt_o 0, all valid/ready outputs 0, busy_o 0.
// - States: Idle -> Issue -> WaitR | WaitB -> Idle.
// - Idle: if any req_trans_valid_i, pick first asserted index at or after ptr_q (wrapping mod NumReq);
//   register it as owner, go Issue. No request: stay Idle. Arbitration costs exactly 1 cycle.
// - Issue: phy_trans_* = owner's; req_trans_ready_o[owner] = phy_trans_ready_i, others 0.
//   On handshake latch owner's trans.write; go WaitB if write else WaitR.
//   Owner drops valid before handshake (protocol violation): return to Idle, no pointer update.
// - WaitB: TX channel muxed to owner (phy_tx_* <= owner, req_tx_ready_o[owner] = phy_tx_ready_i);
//   B muxed to owner. On phy_b_valid_i & req_b_ready_i[owner]: ptr_q = owner+1 (wrap), go Idle.
// - WaitR: RX muxed to owner, phy_rx_ready_o = req_rx_ready_i[owner].
//   On RX handshake with phy_rx_last_i: ptr_q = owner+1 (wrap), go Idle.
// - Non-owners always see trans_ready/tx_ready/rx_valid/b_valid = 0. TX handshakes and
//   stray B/RX outside the matching Wait state are not forwarded (ready 0 to PHY).
// - Shared data outputs (rx_data, rx_last, rx_error, b_error) are driven straight from PHY; only valids are gated.
// - Completion and a new request in the same cycle: complete first, re-arbitrate next Idle cycle
//   (1 dead cycle between transfers, by design: matches PHY's own Idle gap).
// - Pointer width $clog2(NumReq); wrap from NumReq-1 to 0 for non-power-of-2 NumReq.
// - Only one transfer outstanding at a time; no reordering, no pre-arbitration during Wait states.
// - Reset mid-transfer: immediate return to reset state; requesters must also be reset.
// TESTING
// 1 Reset: all outputs 0, busy_o 0; after release with no requests -> stays Idle indefinitely.
// 2 Req0 and req1 read valid together -> req0 granted (gnt_o=01), 4-beat RX routed only to req0;
//   after last beat req1 granted (gnt_o=10) on the cycle after Idle.
// 3 Req1 write burst 2 beats -> TX data 0xA5A5,0x5A5A reaches PHY with strb from req1; B routed to req1,
//   req0 b_valid stays 0; pointer then points at 0.
// 4 Fairness, NumReq=3, all requesting continuously -> grant order 0,1,2,0,1,2 over 6 transfers.
// 5 req_rx_ready_i[owner] low for 3 cycles during read -> phy_rx_ready_o low same cycles, no beats lost.
// 6 Assert rst_ni low in WaitB with TX half done -> next cycle gnt_o=0, busy_o=0, all valids 0.

Source files
------------

// File: rtl/hyperbus_trans_arbiter.sv
// Round-robin arbiter sharing one HyperBus PHY transaction port among NumReq
// requesters. A grant covers a whole transfer and is held until its response
// completes: the B handshake for writes, or the last R beat for reads.

package hyperbus_trans_arbiter_pkg;

  typedef struct packed {
    logic        write;
    logic        address_space;
    logic        burst_type;
    logic [31:0] address;
    logic [15:0] burst;
  } hyper_tf_t;

endpackage

module hyperbus_trans_arbiter
  import hyperbus_trans_arbiter_pkg::*;
#(
  parameter int unsigned NumReq   = 2,
  parameter int unsigned NumChips = 2
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  // requester transfer channel
  input  logic      [NumReq-1:0]             req_trans_valid_i,
  output logic      [NumReq-1:0]             req_trans_ready_o,
  input  hyper_tf_t [NumReq-1:0]             req_trans_i,
  input  logic      [NumReq-1:0][NumChips-1:0] req_trans_cs_i,
  // requester TX channel
  input  logic      [NumReq-1:0]             req_tx_valid_i,
  output logic      [NumReq-1:0]             req_tx_ready_o,
  input  logic      [NumReq-1:0][15:0]       req_tx_data_i,
  input  logic      [NumReq-1:0][1:0]        req_tx_strb_i,
  input  logic      [NumReq-1:0]             req_tx_last_i,
  // requester RX channel
  output logic      [NumReq-1:0]             req_rx_valid_o,
  input  logic      [NumReq-1:0]             req_rx_ready_i,
  output logic      [15:0]                   req_rx_data_o,
  output logic                               req_rx_error_o,
  output logic                               req_rx_last_o,
  // requester B channel
  output logic      [NumReq-1:0]             req_b_valid_o,
  input  logic      [NumReq-1:0]             req_b_ready_i,
  output logic                               req_b_error_o,
  // PHY transfer channel
  output logic                               phy_trans_valid_o,
  input  logic                               phy_trans_ready_i,
  output hyper_tf_t                          phy_trans_o,
  output logic      [NumChips-1:0]           phy_trans_cs_o,
  // PHY TX channel
  output logic                               phy_tx_valid_o,
  input  logic                               phy_tx_ready_i,
  output logic      [15:0]                   phy_tx_data_o,
  output logic      [1:0]                    phy_tx_strb_o,
  output logic                               phy_tx_last_o,
  // PHY RX channel
  input  logic                               phy_rx_valid_i,
  output logic                               phy_rx_ready_o,
  input  logic      [15:0]                   phy_rx_data_i,
  input  logic                               phy_rx_error_i,
  input  logic                               phy_rx_last_i,
  // PHY B channel
  input  logic                               phy_b_valid_i,
  output logic                               phy_b_ready_o,
  input  logic                               phy_b_error_i,
  // status
  output logic      [NumReq-1:0]             gnt_o,
  output logic                               busy_o
);

  localparam int unsigned     PtrW    = $clog2(NumReq);
  localparam logic [PtrW-1:0] LastIdx = PtrW'(NumReq - 1);

  typedef enum logic [1:0] {
    Idle,
    Issue,
    WaitR,
    WaitB
  } state_e;

  state_e          state_q, state_d;
  logic [PtrW-1:0] ptr_q, ptr_d;
  logic [PtrW-1:0] owner_q, owner_d;
  logic [PtrW-1:0] owner_inc;
  logic [PtrW-1:0] cand_sel;
  int unsigned     cand;
  logic            found;

  // State, round-robin pointer and owner registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= Idle;
      ptr_q   <= '0;
      owner_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
    end
  end

  // Arbitration, channel routing and next-state logic
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    found    = 1'b0;
    cand     = 0;
    cand_sel = '0;

    owner_inc = (owner_q == LastIdx) ? '0 : owner_q + 1'b1;

    // Payloads follow the owner unconditionally; only handshakes are gated
    phy_trans_o    = req_trans_i[owner_q];
    phy_trans_cs_o = req_trans_cs_i[owner_q];
    phy_tx_data_o  = req_tx_data_i[owner_q];
    phy_tx_strb_o  = req_tx_strb_i[owner_q];
    phy_tx_last_o  = req_tx_last_i[owner_q];
    req_rx_data_o  = phy_rx_data_i;
    req_rx_error_o = phy_rx_error_i;
    req_rx_last_o  = phy_rx_last_i;
    req_b_error_o  = phy_b_error_i;

    phy_trans_valid_o = 1'b0;
    phy_tx_valid_o    = 1'b0;
    phy_rx_ready_o    = 1'b0;
    phy_b_ready_o     = 1'b0;
    req_trans_ready_o = '0;
    req_tx_ready_o    = '0;
    req_rx_valid_o    = '0;
    req_b_valid_o     = '0;

    busy_o = (state_q != Idle);
    gnt_o  = '0;
    if (state_q != Idle) begin
      gnt_o[owner_q] = 1'b1;
    end

    unique case (state_q)
      Idle: begin
        // Scan from ptr_q upward, wrapping modulo NumReq; the first hit wins
        for (int unsigned i = 0; i < NumReq; i++) begin
          cand = 32'(ptr_q) + i;
          if (cand >= NumReq) begin
            cand = cand - NumReq;
          end
          cand_sel = PtrW'(cand);
          if (!found && req_trans_valid_i[cand_sel]) begin
            found   = 1'b1;
            owner_d = cand_sel;
          end
        end
        if (found) begin
          state_d = Issue;
        end
      end

      Issue: begin
        phy_trans_valid_o          = req_trans_valid_i[owner_q];
        req_trans_ready_o[owner_q] = phy_trans_ready_i;
        // A withdrawn request abandons the grant without advancing the pointer
        if (!req_trans_valid_i[owner_q]) begin
          state_d = Idle;
        end else if (phy_trans_ready_i) begin
          state_d = req_trans_i[owner_q].write ? WaitB : WaitR;
        end
      end

      WaitB: begin
        phy_tx_valid_o          = req_tx_valid_i[owner_q];
        req_tx_ready_o[owner_q] = phy_tx_ready_i;
        req_b_valid_o[owner_q]  = phy_b_valid_i;
        phy_b_ready_o           = req_b_ready_i[owner_q];
        if (phy_b_valid_i && req_b_ready_i[owner_q]) begin
          ptr_d   = owner_inc;
          state_d = Idle;
        end
      end

      WaitR: begin
        req_rx_valid_o[owner_q] = phy_rx_valid_i;
        phy_rx_ready_o          = req_rx_ready_i[owner_q];
        if (phy_rx_valid_i && req_rx_ready_i[owner_q] && phy_rx_last_i) begin
          ptr_d   = owner_inc;
          state_d = Idle;
        end
      end

      default: state_d = Idle;
    endcase
  end

endmodule
